alu_mp_sequencer: RTL

//  Multi-precision sequencer for the 8-bit arithmetic unit (byte-wide A/B/S/cin in, D/cout/z out).

---
 rtl/alu_mp_sequencer_pkg.sv | 24 ++
 rtl/alu_mp_sequencer_if.sv | 30 +++
 rtl/alu_byte_shifter.sv | 48 ++++
 rtl/alu_mp_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_mp_sequencer_pkg.sv
// rtl/alu_mp_sequencer_pkg.sv - shared constants, state and select encodings for the multi-precision sequencer
package alu_mp_sequencer_pkg;

  localparam int AU_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    AU_ADD = 2'd0,
    AU_SUB = 2'd1,
    AU_AND = 2'd2,
    AU_XOR = 2'd3
  } au_sel_e;

  // Byte index needs at least one bit even for a single-byte build.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/alu_mp_sequencer_if.sv
// rtl/alu_mp_sequencer_if.sv - request/response handshake bundle between datapath control and sequencer
interface alu_mp_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   req_sel;
  logic         req_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_d;
  logic         rsp_cout;
  logic         rsp_z;

  modport master (
    output req_valid, req_a, req_b, req_sel, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_d, rsp_cout, rsp_z
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_d, rsp_cout, rsp_z
  );

endinterface

// File: rtl/alu_byte_shifter.sv
// rtl/alu_byte_shifter.sv - W-bit register that loads in parallel or shifts right by one byte
module alu_byte_shifter
  import alu_mp_sequencer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [W-1:0]         load_val_i,
  input  logic                 shift_i,
  input  logic [AU_BYTE_W-1:0] byte_i,
  output logic [W-1:0]         q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] shifted;

  // New byte enters at the top so the low byte is always the next one to process.
  generate
    if (W > AU_BYTE_W) begin : g_wide
      assign shifted = {byte_i, q_q[W-1:AU_BYTE_W]};
    end else begin : g_byte
      assign shifted = byte_i;
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = shifted;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_mp_sequencer.sv
// rtl/alu_mp_sequencer.sv - feeds one NBYTES-wide op to the 8-bit unit LSB first, chaining carry and zero
module alu_mp_sequencer
  import alu_mp_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_mp_sequencer_if.slave    bus,
  output logic [AU_BYTE_W-1:0] au_a_o,
  output logic [AU_BYTE_W-1:0] au_b_o,
  output logic [1:0]           au_s_o,
  output logic                 au_cin_o,
  input  logic [AU_BYTE_W-1:0] au_d_i,
  input  logic                 au_cout_i,
  input  logic                 au_z_i
);

  localparam int W    = AU_BYTE_W * NBYTES;
  localparam int IDXW = idx_width(NBYTES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  seq_state_e      state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic            carry_q, carry_d;
  logic            zacc_q, zacc_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic         accept;
  logic         running;
  logic         done;
  logic [W-1:0] a_sh;
  logic [W-1:0] b_sh;
  logic [W-1:0] res;
  logic         unused_sh;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    running = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        running = 1'b1;
        if (idx_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero flag is the AND of the per-byte unit flags, never a decode of res.
  always_comb begin
    sel_d   = sel_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    idx_d   = idx_q;
    if (accept) begin
      sel_d   = bus.req_sel;
      carry_d = bus.req_cin;
      zacc_d  = 1'b1;
      idx_d   = '0;
    end else if (running) begin
      carry_d = au_cout_i;
      zacc_d  = zacc_q & au_z_i;
      idx_d   = (idx_q == LAST) ? '0 : idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      idx_q   <= idx_d;
    end
  end

  alu_byte_shifter #(.W(W)) u_a_sh (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (accept),
    .load_val_i (bus.req_a),
    .shift_i    (running),
    .byte_i     ('0),
    .q_o        (a_sh)
  );

  alu_byte_shifter #(.W(W)) u_b_sh (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (accept),
    .load_val_i (bus.req_b),
    .shift_i    (running),
    .byte_i     ('0),
    .q_o        (b_sh)
  );

  alu_byte_shifter #(.W(W)) u_res (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (accept),
    .load_val_i ('0),
    .shift_i    (running),
    .byte_i     (au_d_i),
    .q_o        (res)
  );

  // Only the low byte of each operand shifter reaches the unit.
  assign unused_sh = ^{a_sh, b_sh};

  assign au_a_o   = running ? a_sh[AU_BYTE_W-1:0] : '0;
  assign au_b_o   = running ? b_sh[AU_BYTE_W-1:0] : '0;
  assign au_s_o   = running ? sel_q : 2'b00;
  assign au_cin_o = running & carry_q;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = done;
  assign bus.rsp_d     = done ? res : '0;
  assign bus.rsp_cout  = done & carry_q;
  assign bus.rsp_z     = done & zacc_q;

endmodule
